wb_stage: RTL and testbench

//  Writeback stage directly downstream of the memory stage; single-entry MEM/WB register with valid/ready handshake.

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/wb_trap_encode.sv | 20 ++
 rtl/wb_stage.sv | 149 ++++++++++++++
 tb/tb_wb_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 datapath widths, memory-exception encodings and mcause codes.
package rv32_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned RADDR_W    = 5;
    localparam int unsigned CAUSE_W    = 4;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_PAGE     = 2'b10,
        EXC_ACCESS   = 2'b11
    } mem_exc_e;

    localparam logic [CAUSE_W-1:0] MCAUSE_LD_MISALIGN = 4'd4;
    localparam logic [CAUSE_W-1:0] MCAUSE_LD_ACCESS   = 4'd5;
    localparam logic [CAUSE_W-1:0] MCAUSE_ST_MISALIGN = 4'd6;
    localparam logic [CAUSE_W-1:0] MCAUSE_ST_ACCESS   = 4'd7;
    localparam logic [CAUSE_W-1:0] MCAUSE_LD_PAGE     = 4'd13;
    localparam logic [CAUSE_W-1:0] MCAUSE_ST_PAGE     = 4'd15;

    // Pending trap request presented to the CSR/trap unit.
    typedef struct packed {
        logic [CAUSE_W-1:0]    cause;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] tval;
    } trap_req_t;

endpackage

// File: rtl/wb_trap_encode.sv
// Maps a memory-exception type plus load/store flag onto an mcause code.
module wb_trap_encode
    import rv32_pkg::*;
(
    input  logic [1:0] exc_type_i,
    input  logic       is_store_i,
    output logic [3:0] cause_o
);

    // Type 00 with an exception flagged is treated as an access fault.
    always_comb begin
        cause_o = is_store_i ? MCAUSE_ST_ACCESS : MCAUSE_LD_ACCESS;
        unique case (mem_exc_e'(exc_type_i))
            EXC_MISALIGN: cause_o = is_store_i ? MCAUSE_ST_MISALIGN : MCAUSE_LD_MISALIGN;
            EXC_PAGE:     cause_o = is_store_i ? MCAUSE_ST_PAGE : MCAUSE_LD_PAGE;
            default:      cause_o = is_store_i ? MCAUSE_ST_ACCESS : MCAUSE_LD_ACCESS;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single-entry MEM/WB register, register-file commit, EX bypass and trap requests.
// Optional retired-instruction counter output instret_o enabled by defining WB_INSTRET_EN.
module wb_stage
    import rv32_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [ADDR_WIDTH-1:0] mem_pc_i,
    input  logic [4:0]            mem_rd_addr_i,
    input  logic                  mem_rd_we_i,
    input  logic                  mem_is_store_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic                  mem_exception_i,
    input  logic [1:0]            mem_exception_type_i,
    input  logic                  flush_i,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  fwd_valid_o,
    output logic [4:0]            fwd_rd_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  trap_valid_o,
    output logic [3:0]            trap_cause_o,
    output logic [ADDR_WIDTH-1:0] trap_pc_o,
    output logic [ADDR_WIDTH-1:0] trap_tval_o,
    input  logic                  trap_ack_i,
    output logic                  retire_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]           instret_o
`endif
);

    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_HOLD = 2'b01,
        WB_TRAP = 2'b10
    } wb_state_t;

    wb_state_t             state_q, state_d;
    logic                  rf_we_q, rf_we_d;
    logic [RADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  retire_q, retire_d;
    logic                  trap_valid_q, trap_valid_d;
    trap_req_t             trap_q, trap_d;
    logic [CAUSE_W-1:0]    enc_cause;

    wb_trap_encode u_trap_encode (
        .exc_type_i (mem_exception_type_i),
        .is_store_i (mem_is_store_i),
        .cause_o    (enc_cause)
    );

    assign mem_ready_o = (state_q != WB_TRAP);

    // Next state and next registered outputs; outputs reflect the entry held after the edge.
    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_d     = 1'b0;
        trap_valid_d = 1'b0;
        trap_d       = trap_q;

        unique case (state_q)
            WB_TRAP: begin
                if (trap_ack_i) begin
                    state_d = WB_IDLE;
                end else begin
                    trap_valid_d = 1'b1;
                end
            end
            default: begin
                if (flush_i || !mem_valid_i) begin
                    state_d = WB_IDLE;
                end else if (mem_exception_i) begin
                    state_d      = WB_TRAP;
                    trap_valid_d = 1'b1;
                    trap_d.cause = enc_cause;
                    trap_d.pc    = mem_pc_i;
                    trap_d.tval  = mem_addr_i;
                end else begin
                    state_d    = WB_HOLD;
                    rf_we_d    = mem_rd_we_i && (mem_rd_addr_i != 5'd0);
                    rf_waddr_d = mem_rd_addr_i;
                    rf_wdata_d = mem_data_i;
                    retire_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WB_IDLE;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_q     <= 1'b0;
            trap_valid_q <= 1'b0;
            trap_q       <= '0;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_q     <= retire_d;
            trap_valid_q <= trap_valid_d;
            trap_q       <= trap_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign fwd_valid_o  = rf_we_q;
    assign fwd_rd_o     = rf_waddr_q;
    assign fwd_data_o   = rf_wdata_q;
    assign retire_o     = retire_q;
    assign trap_valid_o = trap_valid_q;
    assign trap_cause_o = trap_q.cause;
    assign trap_pc_o    = trap_q.pc;
    assign trap_tval_o  = trap_q.tval;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Counts cycles in which retire_o is high; wraps naturally at 2^64.
    always_comb begin
        instret_d = instret_q + 64'(retire_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, corner sequences and a randomized model run.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_valid_i, mem_rd_we_i, mem_is_store_i, mem_exception_i, flush_i, trap_ack_i;
    logic [31:0] mem_pc_i, mem_data_i, mem_addr_i;
    logic [4:0]  mem_rd_addr_i;
    logic [1:0]  mem_exception_type_i;
    logic        mem_ready_o, rf_we_o, fwd_valid_o, trap_valid_o, retire_o;
    logic [4:0]  rf_waddr_o, fwd_rd_o;
    logic [31:0] rf_wdata_o, fwd_data_o, trap_pc_o, trap_tval_o;
    logic [3:0]  trap_cause_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .mem_valid_i          (mem_valid_i),
        .mem_ready_o          (mem_ready_o),
        .mem_pc_i             (mem_pc_i),
        .mem_rd_addr_i        (mem_rd_addr_i),
        .mem_rd_we_i          (mem_rd_we_i),
        .mem_is_store_i       (mem_is_store_i),
        .mem_data_i           (mem_data_i),
        .mem_addr_i           (mem_addr_i),
        .mem_exception_i      (mem_exception_i),
        .mem_exception_type_i (mem_exception_type_i),
        .flush_i              (flush_i),
        .rf_we_o              (rf_we_o),
        .rf_waddr_o           (rf_waddr_o),
        .rf_wdata_o           (rf_wdata_o),
        .fwd_valid_o          (fwd_valid_o),
        .fwd_rd_o             (fwd_rd_o),
        .fwd_data_o           (fwd_data_o),
        .trap_valid_o         (trap_valid_o),
        .trap_cause_o         (trap_cause_o),
        .trap_pc_o            (trap_pc_o),
        .trap_tval_o          (trap_tval_o),
        .trap_ack_i           (trap_ack_i),
        .retire_o             (retire_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o            (instret_o)
`endif
    );

    typedef struct {
        logic        st;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] addr;
        logic        exc;
        logic [1:0]  typ;
        logic        e_we;
        logic        e_ret;
        logic        e_tv;
        logic [3:0]  e_cause;
    } vec_t;

    vec_t       vt [12];
    logic [3:0] cause_tab [2][4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic we, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] data, input logic [31:0] addr,
                         input logic exc, input logic [1:0] typ);
        mem_valid_i = v;  mem_is_store_i = st; mem_rd_we_i = we; mem_rd_addr_i = rd;
        mem_pc_i = pc;    mem_data_i = data;   mem_addr_i = addr;
        mem_exception_i = exc; mem_exception_type_i = typ;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
        flush_i = 1'b0;
        trap_ack_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic ret, input logic tv, input logic [3:0] c,
                             input logic [31:0] pc, input logic [31:0] tval);
        chk({tag, ".rf_we"}, 64'(rf_we_o), 64'(we));
        chk({tag, ".fwd_valid"}, 64'(fwd_valid_o), 64'(we));
        chk({tag, ".retire"}, 64'(retire_o), 64'(ret));
        chk({tag, ".trap_valid"}, 64'(trap_valid_o), 64'(tv));
        chk({tag, ".ready"}, 64'(mem_ready_o), 64'(!tv));
        if (we) begin
            chk({tag, ".waddr"}, 64'(rf_waddr_o), 64'(wa));
            chk({tag, ".wdata"}, 64'(rf_wdata_o), 64'(wd));
            chk({tag, ".fwd_rd"}, 64'(fwd_rd_o), 64'(wa));
            chk({tag, ".fwd_data"}, 64'(fwd_data_o), 64'(wd));
        end
        if (tv) begin
            chk({tag, ".cause"}, 64'(trap_cause_o), 64'(c));
            chk({tag, ".tpc"}, 64'(trap_pc_o), 64'(pc));
            chk({tag, ".tval"}, 64'(trap_tval_o), 64'(tval));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".rf_we"}, 64'(rf_we_o), 64'd0);
        chk({tag, ".waddr"}, 64'(rf_waddr_o), 64'd0);
        chk({tag, ".wdata"}, 64'(rf_wdata_o), 64'd0);
        chk({tag, ".fwd"}, {31'd0, fwd_valid_o, fwd_rd_o, fwd_data_o}, 64'd0);
        chk({tag, ".retire"}, 64'(retire_o), 64'd0);
        chk({tag, ".trap"}, {27'd0, trap_valid_o, trap_cause_o, trap_pc_o}, 64'd0);
        chk({tag, ".tval"}, 64'(trap_tval_o), 64'd0);
        chk({tag, ".ready"}, 64'(mem_ready_o), 64'd1);
`ifdef WB_INSTRET_EN
        chk({tag, ".instret"}, instret_o, 64'd0);
`endif
    endtask

    initial begin
        logic        r_tp, r_we, r_ret;
        logic [4:0]  r_rd;
        logic [31:0] r_data, r_pc, r_tval;
        logic [3:0]  r_cause;
        int          retired;

        // Cause lookup indexed [is_store][type]; type 00 falls back to access fault.
        cause_tab[0] = '{4'd5, 4'd4, 4'd13, 4'd5};
        cause_tab[1] = '{4'd7, 4'd6, 4'd15, 4'd7};

        vt[0]  = '{1'b0, 1'b1, 5'd5,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0};
        vt[1]  = '{1'b0, 1'b1, 5'd0,  32'h0000_0014, 32'h0000_0001, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[2]  = '{1'b0, 1'b1, 5'd7,  32'h0000_0100, 32'h1234_5678, 32'h0000_2004, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 4'd13};
        vt[3]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0104, 32'h0, 32'h0000_0003, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 4'd6};
        vt[4]  = '{1'b0, 1'b1, 5'd9,  32'h0000_0108, 32'h0, 32'h0000_0005, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 4'd4};
        vt[5]  = '{1'b1, 1'b0, 5'd0,  32'h0000_010C, 32'h0, 32'h8000_0000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 4'd15};
        vt[6]  = '{1'b0, 1'b1, 5'd3,  32'h0000_0110, 32'h0, 32'hFFFF_FFF0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'd5};
        vt[7]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0114, 32'h0, 32'h4000_0000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'd7};
        vt[8]  = '{1'b0, 1'b1, 5'd4,  32'h0000_0118, 32'h0, 32'h0000_0040, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'd5};
        vt[9]  = '{1'b1, 1'b0, 5'd0,  32'h0000_011C, 32'h0, 32'h0000_0044, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'd7};
        vt[10] = '{1'b1, 1'b0, 5'd6,  32'h0000_0120, 32'h5555_AAAA, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[11] = '{1'b0, 1'b1, 5'd31, 32'h0000_0124, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0};

        rst_ni = 1'b0;
        idle_in();
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed vectors, each started from an empty stage.
        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(1'b1, vt[i].st, vt[i].we, vt[i].rd, vt[i].pc, vt[i].data, vt[i].addr, vt[i].exc, vt[i].typ);
            step();
            check_out(tag, vt[i].e_we, vt[i].rd, vt[i].data, vt[i].e_ret, vt[i].e_tv,
                      vt[i].e_cause, vt[i].pc, vt[i].addr);
            idle_in();
            if (vt[i].e_tv) begin
                trap_ack_i = 1'b1;
                step();
                trap_ack_i = 1'b0;
                check_out({tag, ".ack"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            end else begin
                step();
                check_out({tag, ".after"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            end
        end

        // Trap held for 5 cycles without ack (flush ignored), then ack+flush with a new instruction offered.
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'h0, 32'h0000_0003, 1'b1, 2'b01);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h300 + 32'(k), 32'hA0 + 32'(k), 32'h0, 1'b0, 2'b00);
            flush_i = (k == 2);
            step();
            check_out($sformatf("trap_hold%0d", k), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 4'd6, 32'h200, 32'h3);
        end
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0400, 32'h0000_0BAD, 32'h0, 1'b0, 2'b00);
        flush_i = 1'b1;
        trap_ack_i = 1'b1;
        step();
        check_out("ack_cycle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        idle_in();
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0404, 32'h0000_0600D, 32'h0, 1'b0, 2'b00);
        step();
        check_out("post_ack", 1'b1, 5'd8, 32'h600D, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0);

        // Back-to-back stream; flush coincides with the third instruction.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(k), 32'h500 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 32'h0, 1'b0, 2'b00);
            flush_i = (k == 3);
            step();
            if (k == 3)
                check_out("b2b3", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            else
                check_out($sformatf("b2b%0d", k), 1'b1, 5'(k), 32'hC0DE_0000 + 32'(k), 1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        idle_in();
        step();

        // Asynchronous reset while an entry is held.
        drive(1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0600, 32'h1111_2222, 32'h0, 1'b0, 2'b00);
        step();
        check_out("pre_rst", 1'b1, 5'd12, 32'h1111_2222, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        idle_in();
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;

`ifdef WB_INSTRET_EN
        // Ten retires interleaved with one acknowledged trap.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(k + 1), 32'h700 + 32'(4 * k), 32'(k), 32'h0, 1'b0, 2'b00);
            step();
            if (k == 4) begin
                drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0800, 32'h0, 32'h0000_0900, 1'b1, 2'b10);
                step();
                idle_in();
                trap_ack_i = 1'b1;
                step();
                trap_ack_i = 1'b0;
            end
        end
        idle_in();
        step();
        step();
        chk("instret10", instret_o, 64'd10);
`endif

        // Randomized run against a transaction-level model.
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        r_tp = 1'b0; r_cause = '0; r_pc = '0; r_tval = '0;
        retired = 0;
        for (int i = 0; i < 400; i++) begin
            logic v, st, we, exc, fl, ack;
            logic [1:0] typ;
            logic [4:0] rd;
            logic [31:0] pc, data, addr;
            v    = ($urandom_range(0, 9) < 7);
            st   = 1'($urandom);
            we   = 1'($urandom);
            exc  = ($urandom_range(0, 9) < 2);
            fl   = ($urandom_range(0, 9) == 0);
            ack  = ($urandom_range(0, 9) < 3);
            typ  = 2'($urandom);
            rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pc   = $urandom; data = $urandom; addr = $urandom;
            drive(v, st, we, rd, pc, data, addr, exc, typ);
            flush_i = fl;
            trap_ack_i = ack;
            r_we = 1'b0; r_ret = 1'b0; r_rd = rd; r_data = data;
            if (r_tp) begin
                if (ack) r_tp = 1'b0;
            end else if (v && !fl) begin
                if (exc) begin
                    r_tp = 1'b1;
                    r_cause = cause_tab[st][typ];
                    r_pc = pc;
                    r_tval = addr;
                end else begin
                    r_ret = 1'b1;
                    r_we = we && (rd != 5'd0);
                    retired++;
                end
            end
            step();
            check_out($sformatf("rnd%0d", i), r_we, r_rd, r_data, r_ret, r_tp, r_cause, r_pc, r_tval);
        end
        idle_in();
        trap_ack_i = 1'b1;
        step();
        step();
`ifdef WB_INSTRET_EN
        chk("instret_rnd", instret_o, 64'(retired));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
